// File: rtl/shared_adder_arb.sv
// Two-requester arbiter in front of one shared ripple-carry add/subtract unit.
// Round-robin grant in IDLE, one-cycle execute, then hold the result until the consumer takes it.
module shared_adder_arb #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_op,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_op,
  input  logic         req1_cin,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] resp_s,
  output logic         resp_cout,
  output logic         resp_ov
);

  // state | meaning
  // IDLE  | waiting for a request; grant and accept combinationally
  // EXEC  | operands latched; result registered at end of cycle
  // RESP  | result presented until resp_ready
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state, state_nxt;
  logic         rr_ptr;
  logic         grant0, grant1;
  logic [N-1:0] a_q, b_q;
  logic         op_q, cin_q, id_q;
  logic [N-1:0] b_eff, sum;
  logic         c_msb_in, c_out;

  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        // gate with rst_n so no ready is shown while reset is held
        if (rst_n) begin
          grant0 = req0_valid && (!req1_valid || !rr_ptr);
          grant1 = req1_valid && (!req0_valid || rr_ptr);
        end
        if (grant0 || grant1) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign resp_valid = (state == RESP);

  // Subtract is A + ~B + ~borrow_in; carries stay un-inverted until the output.
  assign b_eff = op_q ? ~b_q : b_q;

  always_comb begin
    logic c;
    sum      = '0;
    c_msb_in = 1'b0;
    c        = cin_q ^ op_q;
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) c_msb_in = c;
      sum[i] = a_q[i] ^ b_eff[i] ^ c;
      c      = (a_q[i] & b_eff[i]) | (c & (a_q[i] ^ b_eff[i]));
    end
    c_out = c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 1'b0;
      cin_q     <= 1'b0;
      id_q      <= 1'b0;
      resp_s    <= '0;
      resp_cout <= 1'b0;
      resp_ov   <= 1'b0;
      resp_id   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant0 || grant1) begin
        a_q    <= grant1 ? req1_a   : req0_a;
        b_q    <= grant1 ? req1_b   : req0_b;
        op_q   <= grant1 ? req1_op  : req0_op;
        cin_q  <= grant1 ? req1_cin : req0_cin;
        id_q   <= grant1;
        rr_ptr <= !grant1;
      end
      if (state == EXEC) begin
        resp_s    <= sum;
        resp_cout <= c_out ^ op_q;
        resp_ov   <= c_msb_in ^ c_out;
        resp_id   <= id_q;
      end
    end
  end

endmodule
